ex_hazard_ctrl: RTL and testbench
=================================

// Module: ex_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipeline around the EX datapath.
//  Detects load-use hazards that forwarding cannot cover and holds the pipe for multi-cycle
//  EX ops (mul/div) and MEM-stage memory waits. Resolves EX branch redirects.
//  Drives per-stage stall/bubble/flush controls to PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
// PARAMETERS
//  CNT_W        6    width of multi-cycle latency field/counter
//  TO_W         8    width of memory-wait watchdog counter
//  MEM_TIMEOUT  255  memory-wait cycles before the sticky timeout flag sets (must fit in TO_W)
// PORTS
//  clk                      in   1      clock
//  rst                      in   1      async reset, active-high
//  ..._id_rs1_en_i          in   1      ID instruction reads rs1
//  ..._id_rs2_en_i          in   1      ID instruction reads rs2
//  ..._id_rs1_index_i       in   5      ID rs1 index
//  ..._id_rs2_index_i       in   5      ID rs2 index
//  ..._id2ex_mem_read_i     in   1      instruction in EX is a load
//  ..._id2ex_rd_en_i        in   1      instruction in EX writes rd
//  ..._id2ex_rd_index_i     in   5      EX rd index
//  ..._mc_start_i           in   1      instruction in EX is multi-cycle
//  ..._mc_cycles_i          in   CNT_W  EX latency L of that op (0 treated as 1)
//  ..._mem_req_i            in   1      MEM stage holds a memory access
//  ..._mem_ready_i          in   1      memory access completes this cycle
//  ..._redirect_i           in   1      EX branch/jump taken this cycle
//  ..._pc_stall_o           out  1      hold PC
//  ..._if2id_stall_o        out  1      hold IF/ID
//  ..._if2id_flush_o        out  1      load NOP into IF/ID
//  ..._id2ex_stall_o        out  1      hold ID/EX
//  ..._id2ex_bubble_o       out  1      load NOP into ID/EX
//  ..._ex2mem_stall_o       out  1      hold EX/MEM
//  ..._ex2mem_bubble_o      out  1      load NOP into EX/MEM
//  ..._mem2wb_bubble_o      out  1      load NOP into MEM/WB
//  ..._mc_busy_o            out  1      FSM in MC_BUSY
//  ..._mc_done_o            out  1      multi-cycle result valid this cycle
//  ..._mem_timeout_o        out  1      sticky watchdog flag
// BEHAVIOUR
//  Reset: FSM=IDLE, cnt=0, wd=0, timeout=0. All outputs are 0 while rst is high.
//  Hazard terms (combinational):
//  - mem_wait = mem_req & ~mem_ready.
//  - load_use = id2ex_mem_read & id2ex_rd_en & rd!=0 & ((rs1_en & rs1==rd) | (rs2_en & rs2==rd)).
//  FSM IDLE / MC_BUSY; L' = max(L,1):
//  - IDLE & mc_start & L'>1: load cnt=L'-1, go MC_BUSY. mc_stall=1 this cycle.
//  - IDLE & mc_start & L'==1: stay IDLE. mc_done=1, no stall.
//  - MC_BUSY: mc_stall = cnt>1. cnt decrements while cnt>1.
//  - MC_BUSY & cnt==1: mc_done=1. Go IDLE only if ~mem_wait, else hold in MC_BUSY (cnt=1).
//  - mc_start is ignored in MC_BUSY (no retrigger while ID/EX is held).
//  Output priority (first match wins; unlisted outputs are 0):
//  1 mem_wait: pc, if2id, id2ex and ex2mem stall=1; mem2wb_bubble=1.
//  2 mc_stall: pc, if2id and id2ex stall=1; ex2mem_bubble=1.
//  3 redirect: if2id_flush=1, id2ex_bubble=1. PC is not stalled (it loads the target).
//  4 load_use: pc and if2id stall=1; id2ex_bubble=1. Costs exactly one cycle, next cycle forwards.
//  - Redirect or load_use under a higher-priority freeze is not acted on; the source holds it until unfrozen.
//  Watchdog:
//  - wd increments while mem_wait, saturating at MEM_TIMEOUT; clears when ~mem_wait.
//  - wd==MEM_TIMEOUT sets mem_timeout, which clears only on rst.
//  rst mid-operation: FSM returns to IDLE immediately; an in-flight mc op is abandoned.
// TESTING
//  - Load x5 in EX, ID add rs1=x5 -> 1 cycle: pc/if2id stall=1, id2ex_bubble=1. Next cycle all 0.
//  - Load rd=x0, ID reads x0 -> no stall. rs2_en=0 with rs2==rd -> no stall.
//  - mc_start, L=4 -> stall for 3 cycles with ex2mem_bubble=1; mc_done in the 4th cycle; busy cycles 2-4.
//  - L=0 and L=1 -> no stall, mc_done=1 for 1 cycle, FSM stays IDLE.
//  - mem_req with ready low for 3 cycles during MC cnt==1 -> freeze 3 cycles, mem2wb_bubble=1.
//    mc_done held high; FSM goes IDLE on the ready cycle.
//  - redirect with load_use together -> if2id_flush=1, id2ex_bubble=1, pc_stall=0.
//    MEM_TIMEOUT=4, ready low for 6 cycles -> mem_timeout rises on the 5th and stays high.
//  - rst pulse at MC cnt=2 -> mc_busy=0 and all outputs 0 during rst; afterwards IDLE.

Source files
------------

// File: rtl/ex_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use detection, multi-cycle EX hold,
// MEM-wait freeze with a sticky watchdog, and EX redirect flushing.
module ex_hazard_ctrl #(
    parameter int CNT_W       = 6,
    parameter int TO_W        = 8,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_rs1_en_i,
    input  logic             id_rs2_en_i,
    input  logic [4:0]       id_rs1_index_i,
    input  logic [4:0]       id_rs2_index_i,
    input  logic             id2ex_mem_read_i,
    input  logic             id2ex_rd_en_i,
    input  logic [4:0]       id2ex_rd_index_i,
    input  logic             mc_start_i,
    input  logic [CNT_W-1:0] mc_cycles_i,
    input  logic             mem_req_i,
    input  logic             mem_ready_i,
    input  logic             redirect_i,
    output logic             pc_stall_o,
    output logic             if2id_stall_o,
    output logic             if2id_flush_o,
    output logic             id2ex_stall_o,
    output logic             id2ex_bubble_o,
    output logic             ex2mem_stall_o,
    output logic             ex2mem_bubble_o,
    output logic             mem2wb_bubble_o,
    output logic             mc_busy_o,
    output logic             mc_done_o,
    output logic             mem_timeout_o
);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_MC_BUSY = 1'b1
    } state_t;

    localparam logic [TO_W-1:0]  WD_MAX  = TO_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TO_W-1:0]   wd_q, wd_d;
    logic              timeout_q, timeout_d;

    logic              mem_wait_s;
    logic              load_use_s;
    logic [CNT_W-1:0]  lat_eff_s;
    logic              mc_stall_s;
    logic              mc_done_s;

    assign mem_wait_s = mem_req_i & ~mem_ready_i;
    assign load_use_s = id2ex_mem_read_i & id2ex_rd_en_i & (id2ex_rd_index_i != 5'd0) &
                        ((id_rs1_en_i & (id_rs1_index_i == id2ex_rd_index_i)) |
                         (id_rs2_en_i & (id_rs2_index_i == id2ex_rd_index_i)));
    // A zero latency field means a single-cycle op.
    assign lat_eff_s  = (mc_cycles_i == {CNT_W{1'b0}}) ? CNT_ONE : mc_cycles_i;

    // State, counter, watchdog and sticky timeout registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            wd_q      <= {TO_W{1'b0}};
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state logic for the multi-cycle FSM and the watchdog.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (mc_start_i && (lat_eff_s > CNT_ONE)) begin
                    state_d = ST_MC_BUSY;
                    cnt_d   = lat_eff_s - CNT_ONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MC_BUSY: begin
                if (cnt_q > CNT_ONE) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else if (!mem_wait_s) begin
                    // Result handed off; the MEM freeze keeps us parked at cnt==1 otherwise.
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_MC_BUSY;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase

        if (mem_wait_s) begin
            wd_d = (wd_q == WD_MAX) ? wd_q : (wd_q + TO_W'(1));
        end else begin
            wd_d = {TO_W{1'b0}};
        end
        timeout_d = timeout_q | (mem_wait_s & (wd_d == WD_MAX));
    end

    // Output decode: FSM status, then the prioritized pipeline controls.
    always_comb begin
        mc_stall_s      = 1'b0;
        mc_done_s       = 1'b0;
        pc_stall_o      = 1'b0;
        if2id_stall_o   = 1'b0;
        if2id_flush_o   = 1'b0;
        id2ex_stall_o   = 1'b0;
        id2ex_bubble_o  = 1'b0;
        ex2mem_stall_o  = 1'b0;
        ex2mem_bubble_o = 1'b0;
        mem2wb_bubble_o = 1'b0;
        mc_busy_o       = 1'b0;
        mc_done_o       = 1'b0;
        mem_timeout_o   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                mc_stall_s = mc_start_i & (lat_eff_s > CNT_ONE);
                mc_done_s  = mc_start_i & (lat_eff_s == CNT_ONE);
            end
            ST_MC_BUSY: begin
                mc_stall_s = (cnt_q > CNT_ONE);
                mc_done_s  = (cnt_q == CNT_ONE);
            end
            default: begin
                mc_stall_s = 1'b0;
                mc_done_s  = 1'b0;
            end
        endcase

        if (rst) begin
            mc_busy_o = 1'b0;
        end else begin
            mc_busy_o     = (state_q == ST_MC_BUSY);
            mc_done_o     = mc_done_s;
            mem_timeout_o = timeout_q;
            if (mem_wait_s) begin
                pc_stall_o      = 1'b1;
                if2id_stall_o   = 1'b1;
                id2ex_stall_o   = 1'b1;
                ex2mem_stall_o  = 1'b1;
                mem2wb_bubble_o = 1'b1;
            end else if (mc_stall_s) begin
                pc_stall_o      = 1'b1;
                if2id_stall_o   = 1'b1;
                id2ex_stall_o   = 1'b1;
                ex2mem_bubble_o = 1'b1;
            end else if (redirect_i) begin
                if2id_flush_o   = 1'b1;
                id2ex_bubble_o  = 1'b1;
            end else if (load_use_s) begin
                pc_stall_o      = 1'b1;
                if2id_stall_o   = 1'b1;
                id2ex_bubble_o  = 1'b1;
            end else begin
                pc_stall_o      = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Bench for ex_hazard_ctrl: directed scenarios followed by random traffic, every cycle
// compared against a cycle-level reference model of the hazard rules.
module tb_ex_hazard_ctrl;

    localparam int CNT_W = 6;
    localparam int TO_W  = 8;
    localparam int T_OUT = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             id_rs1_en, id_rs2_en;
    logic [4:0]       id_rs1_index, id_rs2_index;
    logic             id2ex_mem_read, id2ex_rd_en;
    logic [4:0]       id2ex_rd_index;
    logic             mc_start;
    logic [CNT_W-1:0] mc_cycles;
    logic             mem_req, mem_ready, redirect;
    logic             pc_stall, if2id_stall, if2id_flush, id2ex_stall, id2ex_bubble;
    logic             ex2mem_stall, ex2mem_bubble, mem2wb_bubble, mc_busy, mc_done, mem_timeout;

    int n_vec = 0;
    int n_err = 0;

    // reference model state: op in flight, cycles left until its result, consecutive wait cycles
    bit m_busy;
    int m_left;
    int m_wait_run;
    bit m_to;

    ex_hazard_ctrl #(.CNT_W(CNT_W), .TO_W(TO_W), .MEM_TIMEOUT(T_OUT)) dut (
        .clk(clk), .rst(rst),
        .id_rs1_en_i(id_rs1_en), .id_rs2_en_i(id_rs2_en),
        .id_rs1_index_i(id_rs1_index), .id_rs2_index_i(id_rs2_index),
        .id2ex_mem_read_i(id2ex_mem_read), .id2ex_rd_en_i(id2ex_rd_en),
        .id2ex_rd_index_i(id2ex_rd_index),
        .mc_start_i(mc_start), .mc_cycles_i(mc_cycles),
        .mem_req_i(mem_req), .mem_ready_i(mem_ready), .redirect_i(redirect),
        .pc_stall_o(pc_stall), .if2id_stall_o(if2id_stall), .if2id_flush_o(if2id_flush),
        .id2ex_stall_o(id2ex_stall), .id2ex_bubble_o(id2ex_bubble),
        .ex2mem_stall_o(ex2mem_stall), .ex2mem_bubble_o(ex2mem_bubble),
        .mem2wb_bubble_o(mem2wb_bubble), .mc_busy_o(mc_busy), .mc_done_o(mc_done),
        .mem_timeout_o(mem_timeout)
    );

    always #5 clk = ~clk;

    // bit order: pc_st if2id_st if2id_fl id2ex_st id2ex_bub ex2mem_st ex2mem_bub mem2wb_bub busy done timeout
    function automatic logic [10:0] model_out();
        bit mw, lu, st, dn;
        int lat;
        logic [10:0] o;
        o = 11'd0;
        if (rst) return o;
        mw  = mem_req && !mem_ready;
        lu  = id2ex_mem_read && id2ex_rd_en && (id2ex_rd_index != 5'd0) &&
              ((id_rs1_en && id_rs1_index == id2ex_rd_index) ||
               (id_rs2_en && id_rs2_index == id2ex_rd_index));
        lat = (mc_cycles == 0) ? 1 : int'(mc_cycles);
        if (m_busy) begin
            st = (m_left > 1);
            dn = (m_left == 1);
        end else begin
            st = mc_start && (lat > 1);
            dn = mc_start && (lat == 1);
        end
        if (mw)            o[10:3] = 8'b1101_0101;
        else if (st)       o[10:3] = 8'b1101_0010;
        else if (redirect) o[10:3] = 8'b0010_1000;
        else if (lu)       o[10:3] = 8'b1100_1000;
        else               o[10:3] = 8'b0000_0000;
        o[2] = m_busy;
        o[1] = dn;
        o[0] = m_to;
        return o;
    endfunction

    task automatic model_step();
        bit mw;
        int lat;
        if (rst) begin
            m_busy = 0; m_left = 0; m_wait_run = 0; m_to = 0;
        end else begin
            mw  = mem_req && !mem_ready;
            lat = (mc_cycles == 0) ? 1 : int'(mc_cycles);
            if (!m_busy) begin
                if (mc_start && lat > 1) begin
                    m_busy = 1;
                    m_left = lat - 1;
                end
            end else if (m_left > 1) begin
                m_left = m_left - 1;
            end else if (!mw) begin
                m_busy = 0;
            end
            m_wait_run = mw ? m_wait_run + 1 : 0;
            if (m_wait_run >= T_OUT) m_to = 1;
        end
    endtask

    task automatic cyc(input string tag);
        logic [10:0] obs, exp;
        #2;
        exp = model_out();
        obs = {pc_stall, if2id_stall, if2id_flush, id2ex_stall, id2ex_bubble, ex2mem_stall,
               ex2mem_bubble, mem2wb_bubble, mc_busy, mc_done, mem_timeout};
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic clr();
        id_rs1_en = 1'b0; id_rs2_en = 1'b0; id_rs1_index = 5'd0; id_rs2_index = 5'd0;
        id2ex_mem_read = 1'b0; id2ex_rd_en = 1'b0; id2ex_rd_index = 5'd0;
        mc_start = 1'b0; mc_cycles = '0; mem_req = 1'b0; mem_ready = 1'b0; redirect = 1'b0;
    endtask

    task automatic set_load(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic r1en, input logic r2en);
        id2ex_mem_read = 1'b1; id2ex_rd_en = 1'b1; id2ex_rd_index = rd;
        id_rs1_index = rs1; id_rs2_index = rs2; id_rs1_en = r1en; id_rs2_en = r2en;
    endtask

    initial begin
        m_busy = 0; m_left = 0; m_wait_run = 0; m_to = 0;
        clr();
        rst = 1'b1;
        @(posedge clk); #1;
        cyc("reset0");
        cyc("reset1");
        rst = 1'b0;
        cyc("idle");

        set_load(5'd5, 5'd5, 5'd9, 1'b1, 1'b1); cyc("load_use");
        clr();                                   cyc("load_use_after");
        set_load(5'd0, 5'd0, 5'd0, 1'b1, 1'b1); cyc("load_x0");
        set_load(5'd7, 5'd3, 5'd7, 1'b1, 1'b0); cyc("rs2_disabled");
        set_load(5'd7, 5'd3, 5'd7, 1'b0, 1'b1); cyc("rs2_match");
        clr();

        mc_start = 1'b1; mc_cycles = 6'd4;
        for (int i = 0; i < 4; i++) cyc($sformatf("mc_l4_c%0d", i + 1));
        clr(); cyc("mc_l4_after");
        mc_start = 1'b1; mc_cycles = 6'd0; cyc("mc_l0");
        clr();                               cyc("mc_l0_after");
        mc_start = 1'b1; mc_cycles = 6'd1; cyc("mc_l1");
        clr();                               cyc("mc_l1_after");

        mc_start = 1'b1; mc_cycles = 6'd2; cyc("mc_l2_start");
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc($sformatf("mc_memwait_%0d", i));
        mem_ready = 1'b1;                    cyc("mc_mem_ready");
        clr();                               cyc("mc_mem_after");

        set_load(5'd4, 5'd4, 5'd0, 1'b1, 1'b0); redirect = 1'b1; cyc("redirect_lu");
        clr();

        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 6; i++) cyc($sformatf("wd_wait_%0d", i + 1));
        clr();
        cyc("wd_sticky0");
        cyc("wd_sticky1");

        mc_start = 1'b1; mc_cycles = 6'd4; cyc("rst_mc_start");
        cyc("rst_mc_cnt3");
        rst = 1'b1;                          cyc("rst_mc_in_rst");
        rst = 1'b0; clr();                   cyc("rst_mc_after0");
        cyc("rst_mc_after1");

        for (int i = 0; i < 800; i++) begin
            rst            = ($urandom_range(0, 199) == 0);
            id_rs1_en      = $urandom_range(0, 3) != 0;
            id_rs2_en      = $urandom_range(0, 1) != 0;
            id_rs1_index   = 5'($urandom_range(0, 3));
            id_rs2_index   = 5'($urandom_range(0, 3));
            id2ex_mem_read = $urandom_range(0, 2) == 0;
            id2ex_rd_en    = $urandom_range(0, 3) != 0;
            id2ex_rd_index = 5'($urandom_range(0, 3));
            mc_start       = $urandom_range(0, 5) == 0;
            mc_cycles      = CNT_W'($urandom_range(0, 6));
            mem_req        = $urandom_range(0, 2) == 0;
            mem_ready      = $urandom_range(0, 2) == 0;
            redirect       = $urandom_range(0, 5) == 0;
            cyc("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
